load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequential data-memory access controller for the RISC-V core. It takes a load or store request from the execute stage, driven by the main decoder's `mem_read_enable`/`mem_write_enable` and the instruction's funct3. It runs one transaction on a valid/ready data bus with a separate response channel, aligns store data and byte strobes, and sign- or zero-extends load data. It stalls the pipeline until the access completes.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, byte address width.
- `DATA_WIDTH`, 32, bus data width. Only 32 is supported; 4 byte lanes.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  execute stage presents a memory instruction.
- `mem_read_enable`  in  1  load requested.
- `mem_write_enable`  in  1  store requested.
- `funct3`  in  3  access size and sign: LB/LH/LW/LBU/LHU, SB/SH/SW.
- `addr`  in  ADDR_WIDTH  effective byte address.
- `store_data`  in  DATA_WIDTH  rs2 value.
- `req_ready`  out  1  LSU idle; the request is accepted this cycle.
- `stall`  out  1  high while a transaction is in flight.
- `done`  out  1  one-cycle pulse when the access completes.
- `load_data`  out  DATA_WIDTH  extended load result; valid with `done` for loads.
- `lsu_error`  out  1  one-cycle pulse for misaligned or illegal requests.
- `bus_req_valid`  out  1  bus request valid.
- `bus_req_ready`  in  1  bus accepts request.
- `bus_we`  out  1  1 = write.
- `bus_addr`  out  ADDR_WIDTH  word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wdata`  out  DATA_WIDTH  lane-replicated store data.
- `bus_wstrb`  out  4  byte strobes; 0 for reads.
- `bus_rsp_valid`  in  1  read data or write acknowledge.
- `bus_rdata`  in  DATA_WIDTH  read word.

## Operation
- States: IDLE, REQ, WAIT_RSP, FINISH.
- IDLE:
  - `req_ready`=1.
  - The request is accepted when `req_valid` is high and exactly one of read/write is high.
  - `addr`, funct3, direction and formatted store data are registered.
- Illegal request, with no bus activity, gives `lsu_error` the next cycle. Illegal means any of:
  - both enables high;
  - store funct3 outside {000,001,010};
  - load funct3 outside {000,001,010,100,101};
  - misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
- `req_valid` with neither enable set is ignored.
- Legal request goes to REQ.
- REQ: `bus_req_valid`=1 with stable `bus_we`/`bus_addr`/`bus_wdata`/`bus_wstrb` until `bus_req_ready`, then WAIT_RSP.
- WAIT_RSP: waits for `bus_rsp_valid`. On a load, the extended `bus_rdata` is captured into `load_data`. Then FINISH.
- FINISH: `done`=1 for one cycle, then IDLE.
- Store formatting:
  - SB: byte replicated ×4, strobe `4'b0001<<addr[1:0]`.
  - SH: halfword replicated ×2, strobe `4'b0011<<addr[1:0]`.
  - SW: strobe `4'b1111`.
- Load extraction: lane selected by `addr[1:0]`. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- `load_data` holds its value until the next load completes. Stores leave it unchanged.

## Timing
- Reset values: all registered outputs 0 and state IDLE. `req_ready`=1 and `stall`=0 follow from IDLE.
- `stall` = (state≠IDLE) or (IDLE and a legal request is being accepted). `stall` is combinational so the pipeline freezes in the accept cycle.
- Minimum latency, accept at N:
  - `bus_req_valid` at N+1;
  - if ready at N+1, the response is sampled from N+2;
  - `done` at N+3 with a 0-wait-state response.
- The error path pulses `lsu_error` at N+1. `done` is not asserted.
- `bus_rsp_valid` outside WAIT_RSP is ignored.
- `rst_n` low mid-transaction clears state immediately and asynchronously and drops `bus_req_valid`. A late response after reset is ignored.
- New requests are not accepted in FINISH. Back-to-back accesses are therefore spaced by at least 4 cycles.

## Structure
- `riscv_defines` gains:
  - `lsu_state_t` enum;
  - funct3 constants `FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW`.
- Sub-module `lsu_load_align`: combinational lane select and extension of `bus_rdata` from `addr[1:0]` and funct3. It is instantiated once.

## Test plan
- SW to `0x100` with data `0xDEADBEEF`, `bus_req_ready` high, response in 1 cycle:
  - `bus_wstrb`=1111, `bus_addr`=`0x100`;
  - `done` 3 cycles after accept.
- SB to `0x203` with data `0x000000A5`: `bus_wdata`=`0xA5A5A5A5`, `bus_wstrb`=1000, `bus_addr`=`0x200`.
- LB from `0x301`, `bus_rdata`=`0x12348056`: `load_data`=`0xFFFFFF80`. Same access as LBU gives `0x00000080`. LHU from `0x302` gives `0x00001234`.
- LW from `0x102`: `lsu_error` pulses one cycle later, no `bus_req_valid`, `done` stays 0.
- `bus_req_ready` held low 5 cycles: request fields stable throughout, `stall` high, and a stray `bus_rsp_valid` during REQ is ignored.
- `rst_n` asserted while in WAIT_RSP: outputs zero immediately. A later `bus_rsp_valid` produces no `done`.

Source files
------------

// File: rtl/riscv_defines.sv
// Shared RISC-V core definitions: funct3 encodings for memory instructions
// and the load/store unit state type.
package riscv_defines;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_WAIT_RSP,
        LSU_FINISH
    } lsu_state_t;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

endpackage

// File: rtl/lsu_load_align.sv
// Load data lane select and sign/zero extension of a 32-bit bus read word.
module lsu_load_align
    import riscv_defines::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] shifted;
    logic signed [7:0]     byte_s;
    logic signed [15:0]    half_s;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        byte_s  = shifted[7:0];
        half_s  = shifted[15:0];
        case (funct3)
            FUNCT3_LB:  data = DATA_WIDTH'(byte_s);
            FUNCT3_LH:  data = DATA_WIDTH'(half_s);
            FUNCT3_LBU: data = DATA_WIDTH'(shifted[7:0]);
            FUNCT3_LHU: data = DATA_WIDTH'(shifted[15:0]);
            default:    data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access controller: one load/store per request over a
// valid/ready bus with a separate response channel; stalls until done.
module load_store_unit
    import riscv_defines::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  mem_read_enable,
    input  logic                  mem_write_enable,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] store_data,
    output logic                  req_ready,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  lsu_error,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [3:0]            bus_wstrb,
    input  logic                  bus_rsp_valid,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);

    function automatic logic [3:0] store_strobe(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            FUNCT3_SB: store_strobe = 4'b0001 << off;
            FUNCT3_SH: store_strobe = 4'b0011 << off;
            default:   store_strobe = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] store_format(input logic [2:0] f3,
                                                           input logic [DATA_WIDTH-1:0] d);
        case (f3)
            FUNCT3_SB: store_format = {4{d[7:0]}};
            FUNCT3_SH: store_format = {2{d[15:0]}};
            default:   store_format = d;
        endcase
    endfunction

    lsu_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [2:0]            funct3_q;
    logic [DATA_WIDTH-1:0] aligned_rdata;
    logic                  one_dir, f3_ok, aligned, legal_req, illegal_req;
    logic                  is_half, is_word, idle;

    assign idle    = (state_q == LSU_IDLE);
    assign one_dir = mem_read_enable ^ mem_write_enable;
    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = (funct3[1:0] == 2'b10);
    assign aligned = !(is_half && addr[0]) && !(is_word && (addr[1:0] != 2'b00));

    always_comb begin
        if (mem_write_enable)
            f3_ok = funct3 inside {FUNCT3_SB, FUNCT3_SH, FUNCT3_SW};
        else
            f3_ok = funct3 inside {FUNCT3_LB, FUNCT3_LH, FUNCT3_LW, FUNCT3_LBU, FUNCT3_LHU};
    end

    // Both enables high is caught here because one_dir is then false.
    assign legal_req   = req_valid && one_dir && f3_ok && aligned;
    assign illegal_req = req_valid && (mem_read_enable || mem_write_enable) && !legal_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= LSU_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:     if (legal_req) state_d = LSU_REQ;
            LSU_REQ:      if (bus_req_ready) state_d = LSU_WAIT_RSP;
            LSU_WAIT_RSP: if (bus_rsp_valid) state_d = LSU_FINISH;
            LSU_FINISH:   state_d = LSU_IDLE;
            default:      state_d = LSU_IDLE;
        endcase
    end

    // Stall is combinational so the pipeline freezes in the accept cycle.
    assign req_ready     = idle;
    assign stall         = !idle || legal_req;
    assign done          = (state_q == LSU_FINISH);
    assign bus_req_valid = (state_q == LSU_REQ);
    assign bus_addr      = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .rdata  (bus_rdata),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (aligned_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            funct3_q  <= '0;
            bus_we    <= 1'b0;
            bus_wdata <= '0;
            bus_wstrb <= '0;
            load_data <= '0;
            lsu_error <= 1'b0;
        end else begin
            lsu_error <= idle && illegal_req;
            if (idle && legal_req) begin
                addr_q    <= addr;
                funct3_q  <= funct3;
                bus_we    <= mem_write_enable;
                bus_wdata <= store_format(funct3, store_data);
                bus_wstrb <= mem_write_enable ? store_strobe(funct3, addr[1:0]) : 4'b0000;
            end
            if ((state_q == LSU_WAIT_RSP) && bus_rsp_valid && !bus_we)
                load_data <= aligned_rdata;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed loads, stores, errors and reset.
module tb_load_store_unit;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, mem_read_enable = 1'b0, mem_write_enable = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, store_data = '0;
    logic        req_ready, stall, done, lsu_error;
    logic [31:0] load_data;
    logic        bus_req_valid, bus_we;
    logic        bus_req_ready = 1'b0, bus_rsp_valid = 1'b0;
    logic [31:0] bus_addr, bus_wdata, bus_rdata = '0;
    logic [3:0]  bus_wstrb;

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
        .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .req_ready(req_ready), .stall(stall), .done(done), .load_data(load_data),
        .lsu_error(lsu_error), .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        err;
        logic        is_load;
        logic [31:0] ld;
    } rsp_exp_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_exp_t;

    rsp_exp_t    rsp_q[$];
    bus_exp_t    bus_q[$];
    rsp_exp_t    mon_r;
    bus_exp_t    mon_b;
    int          checks = 0, failures = 0, cyc = 0;
    logic [31:0] ld_hold = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: pops expectations whenever the DUT completes or handshakes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done || lsu_error) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {30'd0, done, lsu_error}, 32'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("rsp_error", 32'(lsu_error), 32'(mon_r.err));
                    chk("rsp_done", 32'(done), 32'(!mon_r.err));
                    if (done) chk("load_data", load_data, mon_r.ld);
                end
            end
            if (bus_req_valid && bus_req_ready) begin
                if (bus_q.size() == 0) begin
                    chk("unexpected_bus", bus_addr, 32'hFFFF_FFFF);
                end else begin
                    mon_b = bus_q.pop_front();
                    chk("bus_we", 32'(bus_we), 32'(mon_b.we));
                    chk("bus_addr", bus_addr, mon_b.addr);
                    chk("bus_wstrb", 32'(bus_wstrb), 32'(mon_b.wstrb));
                    if (mon_b.we) chk("bus_wdata", bus_wdata, mon_b.wdata);
                end
            end
        end
    end

    // Entered and left at 1 time unit after a rising edge with the DUT idle.
    task automatic txn(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                       input int rdy_wait, input bit exp_err, input logic [31:0] exp_wdata,
                       input logic [3:0] exp_wstrb, input logic [31:0] exp_ld);
        int acc_cyc;
        logic [31:0] exp_addr;
        exp_addr = {a[31:2], 2'b00};
        if (rd && !exp_err) ld_hold = exp_ld;
        rsp_q.push_back('{exp_err, rd, ld_hold});
        if (!exp_err) bus_q.push_back('{wr, exp_addr, exp_wdata, wr ? exp_wstrb : 4'b0000});
        req_valid = 1'b1; mem_read_enable = rd; mem_write_enable = wr;
        funct3 = f3; addr = a; store_data = sd;
        @(negedge clk);
        chk({nm, "_accept_stall"}, 32'(stall), 32'(!exp_err));
        chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
        acc_cyc = cyc;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read_enable = 1'b0; mem_write_enable = 1'b0;
        if (exp_err) begin
            @(negedge clk);
            chk({nm, "_no_bus"}, 32'(bus_req_valid), 32'd0);
            chk({nm, "_err_stall"}, 32'(stall), 32'd0);
            repeat (2) begin
                @(negedge clk);
                chk({nm, "_err_quiet"}, {30'd0, done, lsu_error}, 32'd0);
            end
            @(posedge clk); #1;
            return;
        end
        for (int i = 0; i < rdy_wait; i++) begin
            if (i == 1) begin bus_rsp_valid = 1'b1; bus_rdata = 32'hBAD0_BAD0; end
            @(negedge clk);
            chk({nm, "_hold_valid"}, {30'd0, bus_req_valid, stall}, 32'd3);
            chk({nm, "_hold_addr"}, bus_addr, exp_addr);
            chk({nm, "_hold_strb"}, {27'd0, bus_we, bus_wstrb}, {27'd0, wr, wr ? exp_wstrb : 4'b0000});
            if (wr) chk({nm, "_hold_wdata"}, bus_wdata, exp_wdata);
            @(posedge clk); #1;
            bus_rsp_valid = 1'b0;
        end
        bus_req_ready = 1'b1;
        @(negedge clk);
        chk({nm, "_req_valid"}, 32'(bus_req_valid), 32'd1);
        @(posedge clk); #1;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b1; bus_rdata = rdata;
        @(negedge clk);
        chk({nm, "_wait_state"}, {30'd0, done, stall}, 32'd1);
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_latency"}, 32'(cyc - acc_cyc), 32'(3 + rdy_wait));
        @(posedge clk); #1;
        @(negedge clk);
        chk({nm, "_back_idle"}, {30'd0, done, req_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready_stall", {30'd0, req_ready, stall}, 32'd2);
        chk("rst_pulses", {29'd0, done, lsu_error, bus_req_valid}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        txn("sw",      1'b0, 1'b1, FUNCT3_SW, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b0, 32'hDEADBEEF, 4'b1111, 32'h0);
        txn("sb",      1'b0, 1'b1, FUNCT3_SB, 32'h203, 32'h000000A5, 32'h0, 0, 1'b0, 32'hA5A5A5A5, 4'b1000, 32'h0);
        txn("sh",      1'b0, 1'b1, FUNCT3_SH, 32'h202, 32'h1234BEEF, 32'h0, 0, 1'b0, 32'hBEEFBEEF, 4'b1100, 32'h0);
        txn("lb",      1'b1, 1'b0, FUNCT3_LB, 32'h301, 32'h0, 32'h12348056, 0, 1'b0, 32'h0, 4'b0, 32'hFFFFFF80);
        txn("sw_hold", 1'b0, 1'b1, FUNCT3_SW, 32'h104, 32'h01020304, 32'h0, 0, 1'b0, 32'h01020304, 4'b1111, 32'h0);
        txn("lbu",     1'b1, 1'b0, FUNCT3_LBU, 32'h301, 32'h0, 32'h12348056, 0, 1'b0, 32'h0, 4'b0, 32'h00000080);
        txn("lhu",     1'b1, 1'b0, FUNCT3_LHU, 32'h302, 32'h0, 32'h12348056, 0, 1'b0, 32'h0, 4'b0, 32'h00001234);
        txn("lh",      1'b1, 1'b0, FUNCT3_LH, 32'h300, 32'h0, 32'h12348056, 0, 1'b0, 32'h0, 4'b0, 32'hFFFF8056);
        txn("lw_wait", 1'b1, 1'b0, FUNCT3_LW, 32'h300, 32'h0, 32'h12348056, 5, 1'b0, 32'h0, 4'b0, 32'h12348056);
        txn("sb_wait", 1'b0, 1'b1, FUNCT3_SB, 32'h10D, 32'h0000005C, 32'h0, 5, 1'b0, 32'h5C5C5C5C, 4'b0010, 32'h0);

        txn("err_lw",   1'b1, 1'b0, FUNCT3_LW, 32'h102, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 32'h0);
        txn("err_lh",   1'b1, 1'b0, FUNCT3_LH, 32'h101, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 32'h0);
        txn("err_both", 1'b1, 1'b1, FUNCT3_LW, 32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 32'h0);
        txn("err_sf3",  1'b0, 1'b1, 3'b100,    32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 32'h0);
        txn("err_lf3",  1'b1, 1'b0, 3'b011,    32'h100, 32'h0, 32'h0, 0, 1'b1, 32'h0, 4'b0, 32'h0);

        req_valid = 1'b1; funct3 = FUNCT3_LW; addr = 32'h100;
        repeat (3) begin
            @(negedge clk);
            chk("ignored_quiet", {29'd0, stall, bus_req_valid, lsu_error}, 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(posedge clk); #1;

        bus_q.push_back('{1'b0, 32'h300, 32'h0, 4'b0000});
        req_valid = 1'b1; mem_read_enable = 1'b1; funct3 = FUNCT3_LW; addr = 32'h300;
        @(posedge clk); #1;
        req_valid = 1'b0; mem_read_enable = 1'b0; bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        @(negedge clk);
        chk("rst_mid_wait", {30'd0, stall, bus_req_valid}, 32'd2);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready_stall", {30'd0, req_ready, stall}, 32'd2);
        chk("rst_mid_pulses", {29'd0, done, lsu_error, bus_req_valid}, 32'd0);
        chk("rst_mid_bus_addr", bus_addr, 32'd0);
        chk("rst_mid_load_data", load_data, ld_hold & 32'd0);
        ld_hold = '0;
        @(posedge clk); #1;
        rst_n = 1'b1; bus_rsp_valid = 1'b1; bus_rdata = 32'h55555555;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("late_rsp_quiet", {30'd0, done, stall}, 32'd0);
        end
        chk("late_rsp_load_data", load_data, 32'd0);

        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
